// File: rtl/cla16_seq_wide_adder_if.sv
`default_nettype none
// ============================================================================
//  Module   : cla16_seq_wide_adder_if
//  Brief    : Request/response bundle for the sequential wide adder.
//  Revision : 1.0
// ============================================================================
interface cla16_seq_wide_adder_if #(
    parameter int SLICES = 4
);
    localparam int W = 16 * SLICES;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;
    logic         busy;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, cout, overflow, busy
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, cout, overflow, busy
    );
endinterface
`default_nettype wire

// File: rtl/cla16_seq_wide_adder.sv
`default_nettype none
// ============================================================================
//  Module   : cla16_seq_wide_adder
//  Brief    : Multi-cycle W=16*SLICES add/sub sharing one 16-bit rippled CLA.
//  Revision : 1.0
// ============================================================================
module cla16_seq_wide_adder #(
    parameter int SLICES = 4
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    cla16_seq_wide_adder_if.slave bus
);
    localparam int W     = 16 * SLICES;
    localparam int IDX_W = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLICES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [IDX_W-1:0] idx;
    logic [W-1:0]     a_reg;
    logic [W-1:0]     b_reg;
    logic [W-1:0]     sum_reg;
    logic             carry_reg;
    logic             cout_reg;
    logic             ovf_reg;
    logic             out_valid_reg;
    logic             in_ready_c;
    logic             busy_c;
    logic             accept;
    logic             result_taken;

    logic [15:0]      add_a;
    logic [15:0]      add_b;
    logic [15:0]      add_s;
    logic             add_cout;
    logic             blk_c [0:4];

    assign accept       = bus.in_valid & in_ready_c;
    assign result_taken = out_valid_reg & bus.out_ready;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept)          state_nxt = S_RUN;
            S_RUN:   if (idx == LAST_IDX) state_nxt = S_DONE;
            S_DONE:  if (result_taken)    state_nxt = S_IDLE;
            default:                      state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready_c = 1'b0;
        busy_c     = 1'b0;
        case (state)
            S_IDLE:  in_ready_c = 1'b1;
            S_RUN:   busy_c     = 1'b1;
            S_DONE:  busy_c     = 1'b1;
            default: in_ready_c = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Slice select into the shared adder
    // ------------------------------------------------------------------
    always_comb begin
        add_a = 16'h0000;
        add_b = 16'h0000;
        for (int i = 0; i < SLICES; i++) begin
            if (idx == IDX_W'(i)) begin
                add_a = a_reg[i*16 +: 16];
                add_b = b_reg[i*16 +: 16];
            end
        end
    end

    // ------------------------------------------------------------------
    // Shared 16-bit adder: four 4-bit lookahead groups with rippled
    // group carries (CLARippledAdder16 structure).
    // ------------------------------------------------------------------
    assign blk_c[0] = carry_reg;
    assign add_cout = blk_c[4];

    for (genvar blk = 0; blk < 4; blk++) begin : g_cla_blk
        logic [3:0] p;
        logic [3:0] g;
        logic [3:0] c;

        assign p = add_a[blk*4 +: 4] ^ add_b[blk*4 +: 4];
        assign g = add_a[blk*4 +: 4] & add_b[blk*4 +: 4];

        assign c[0] = blk_c[blk];
        assign c[1] = g[0] | (p[0] & c[0]);
        assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                    | (p[2] & p[1] & p[0] & c[0]);
        assign blk_c[blk+1] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                            | (p[3] & p[2] & p[1] & g[0])
                            | (p[3] & p[2] & p[1] & p[0] & c[0]);

        assign add_s[blk*4 +: 4] = p ^ c;
    end

    // ------------------------------------------------------------------
    // Datapath: operand latch, per-slice result write, result flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx           <= '0;
            carry_reg     <= 1'b0;
            sum_reg       <= '0;
            cout_reg      <= 1'b0;
            ovf_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        a_reg     <= bus.a;
                        b_reg     <= bus.sub ? ~bus.b : bus.b;
                        carry_reg <= bus.sub;
                        idx       <= '0;
                    end
                end
                S_RUN: begin
                    for (int i = 0; i < SLICES; i++) begin
                        if (idx == IDX_W'(i)) begin
                            sum_reg[i*16 +: 16] <= add_s;
                        end
                    end
                    carry_reg <= add_cout;
                    if (idx == LAST_IDX) begin
                        // Sign of the result is add_s[15] on the top slice.
                        cout_reg      <= add_cout;
                        ovf_reg       <= (a_reg[W-1] == b_reg[W-1]) &
                                         (add_s[15] != a_reg[W-1]);
                        out_valid_reg <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_DONE: begin
                    if (result_taken) begin
                        out_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.busy      = busy_c;
    assign bus.out_valid = out_valid_reg;
    assign bus.sum       = sum_reg;
    assign bus.cout      = cout_reg;
    assign bus.overflow  = ovf_reg;

endmodule
`default_nettype wire

// File: tb/tb_cla16_seq_wide_adder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cla16_seq_wide_adder
//  Brief    : Directed vector bench for cla16_seq_wide_adder (SLICES 4, 1, 2).
//  Revision : 1.0
// ============================================================================
module tb_cla16_seq_wide_adder;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cla16_seq_wide_adder_if #(.SLICES(4)) if4 ();
    cla16_seq_wide_adder_if #(.SLICES(1)) if1 ();
    cla16_seq_wide_adder_if #(.SLICES(2)) if2 ();

    cla16_seq_wide_adder #(.SLICES(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
    cla16_seq_wide_adder #(.SLICES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    cla16_seq_wide_adder #(.SLICES(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    logic [63:0] a_drv;
    logic [63:0] b_drv;
    logic        sub_drv;
    logic [2:0]  iv;
    logic [2:0]  ordy;
    int          sel;

    assign if4.a = a_drv;        assign if1.a = a_drv[15:0]; assign if2.a = a_drv[31:0];
    assign if4.b = b_drv;        assign if1.b = b_drv[15:0]; assign if2.b = b_drv[31:0];
    assign if4.sub = sub_drv;    assign if1.sub = sub_drv;   assign if2.sub = sub_drv;
    assign if4.in_valid = iv[0]; assign if1.in_valid = iv[1]; assign if2.in_valid = iv[2];
    assign if4.out_ready = ordy[0];
    assign if1.out_ready = ordy[1];
    assign if2.out_ready = ordy[2];

    logic        ov_m, ir_m, busy_m, cout_m, ovf_m;
    logic [63:0] sum_m;

    always_comb begin
        ov_m = if4.out_valid; ir_m = if4.in_ready; busy_m = if4.busy;
        cout_m = if4.cout; ovf_m = if4.overflow; sum_m = if4.sum;
        if (sel == 1) begin
            ov_m = if1.out_valid; ir_m = if1.in_ready; busy_m = if1.busy;
            cout_m = if1.cout; ovf_m = if1.overflow; sum_m = {48'h0, if1.sum};
        end else if (sel == 2) begin
            ov_m = if2.out_valid; ir_m = if2.in_ready; busy_m = if2.busy;
            cout_m = if2.cout; ovf_m = if2.overflow; sum_m = {32'h0, if2.sum};
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    // Waits for out_valid; returns edges elapsed since the acceptance edge.
    task automatic wait_result(output int lat);
        lat = 0;
        while (ov_m !== 1'b1 && lat < 20) begin
            @(posedge clk); @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_op(input int s, input logic [63:0] a, input logic [63:0] b,
                          input logic sb, input logic [63:0] es, input logic ec,
                          input logic eo, input int elat, input string nm);
        int lat;
        sel = s;
        @(negedge clk);
        check({nm, " in_ready idle"}, 64'(ir_m), 64'd1);
        a_drv = a; b_drv = b; sub_drv = sb; iv[s] = 1'b1;
        @(posedge clk); @(negedge clk);
        iv[s] = 1'b0;
        a_drv = {$urandom(), $urandom()};
        b_drv = {$urandom(), $urandom()};
        sub_drv = ~sb;
        check({nm, " busy"}, 64'(busy_m), 64'd1);
        wait_result(lat);
        check({nm, " latency"}, 64'(lat), 64'(elat));
        check({nm, " sum"}, sum_m, es);
        check({nm, " cout"}, 64'(cout_m), 64'(ec));
        check({nm, " overflow"}, 64'(ovf_m), 64'(eo));
        ordy[s] = 1'b1;
        @(posedge clk); @(negedge clk);
        ordy[s] = 1'b0;
        check({nm, " out_valid drop"}, 64'(ov_m), 64'd0);
        check({nm, " in_ready back"}, 64'(ir_m), 64'd1);
    endtask

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        sub;
        logic [63:0] s;
        logic        c;
        logic        o;
        string       nm;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int lat;
        logic seen;

        vecs[0] = '{64'h0000_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0001_0000_0000_0000, 1'b0, 1'b0, "carry_chain"};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0, "full_wrap"};
        vecs[2] = '{64'h5, 64'h7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, "sub_5_7"};
        vecs[3] = '{64'h8000_0000_0000_0000, 64'h1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, "sub_min_1"};
        vecs[4] = '{64'h3, 64'h4, 1'b0, 64'h7, 1'b0, 1'b0, "add_3_4"};
        vecs[5] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, "add_max_1"};
        vecs[6] = '{64'h0, 64'h0, 1'b1, 64'h0, 1'b1, 1'b0, "sub_0_0"};
        vecs[7] = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 64'h2222_2222_2222_2211, 1'b0, 1'b0, "mixed"};

        sel = 0; iv = '0; ordy = '0; a_drv = '0; b_drv = '0; sub_drv = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("reset out_valid", 64'(ov_m), 64'd0);
        check("reset sum", sum_m, 64'd0);
        check("reset cout", 64'(cout_m), 64'd0);
        check("reset overflow", 64'(ovf_m), 64'd0);
        check("reset in_ready", 64'(ir_m), 64'd1);
        check("reset busy", 64'(busy_m), 64'd0);

        for (int i = 0; i < 8; i++)
            run_op(0, vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].s, vecs[i].c, vecs[i].o, 4, vecs[i].nm);

        // Reset mid-RUN after two slices: nothing may ever emerge.
        sel = 0;
        @(negedge clk);
        a_drv = 64'h0000_0000_FFFF_FFFF; b_drv = 64'h1; sub_drv = 1'b0; iv[0] = 1'b1;
        @(posedge clk); @(negedge clk);
        iv[0] = 1'b0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        check("midrun rst out_valid", 64'(ov_m), 64'd0);
        check("midrun rst sum", sum_m, 64'd0);
        check("midrun rst in_ready", 64'(ir_m), 64'd1);
        check("midrun rst busy", 64'(busy_m), 64'd0);
        seen = 1'b0;
        ordy[0] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); @(negedge clk);
            if (ov_m !== 1'b0) seen = 1'b1;
        end
        ordy[0] = 1'b0;
        check("midrun rst no result", 64'(seen), 64'd0);

        // Back-pressure with a second request held pending.
        @(negedge clk);
        a_drv = 64'd3; b_drv = 64'd4; sub_drv = 1'b0; iv[0] = 1'b1;
        @(posedge clk); @(negedge clk);
        a_drv = 64'd10; b_drv = 64'd20;
        wait_result(lat);
        check("bp latency", 64'(lat), 64'd4);
        check("bp sum", sum_m, 64'd7);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); @(negedge clk);
            check("bp hold valid", 64'(ov_m), 64'd1);
            check("bp hold sum", sum_m, 64'd7);
            check("bp hold in_ready", 64'(ir_m), 64'd0);
        end
        ordy[0] = 1'b1;
        @(posedge clk); @(negedge clk);
        ordy[0] = 1'b0;
        check("bp handshake valid", 64'(ov_m), 64'd0);
        check("bp handshake in_ready", 64'(ir_m), 64'd1);
        @(posedge clk); @(negedge clk);
        iv[0] = 1'b0;
        check("bp second accepted", 64'(busy_m), 64'd1);
        wait_result(lat);
        check("bp second latency", 64'(lat), 64'd4);
        check("bp second sum", sum_m, 64'd30);
        ordy[0] = 1'b1;
        @(posedge clk); @(negedge clk);
        ordy[0] = 1'b0;
        check("bp second drop", 64'(ov_m), 64'd0);

        // Narrow configurations.
        run_op(1, 64'hFFFF, 64'h0001, 1'b0, 64'h0000, 1'b1, 1'b0, 1, "s1_wrap");
        run_op(1, 64'h0003, 64'h0005, 1'b1, 64'hFFFE, 1'b0, 1'b0, 1, "s1_sub");
        run_op(2, 64'h7FFF_FFFF, 64'h1, 1'b0, 64'h8000_0000, 1'b0, 1'b1, 2, "s2_ovf");
        run_op(2, 64'h0000_FFFF, 64'h1, 1'b0, 64'h0001_0000, 1'b0, 1'b0, 2, "s2_carry");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
